// File: rtl/soc_uart_tx.sv
// -----------------------------------------------------------------------------
// soc_uart_tx
//   Byte FIFO in front of an 8N1 UART transmitter. The SoC byte-output
//   register strobes bytes in; the transmitter drains the FIFO and sends
//   frames back to back with no idle gap while data is queued.
//
// Parameters
//   CLK_DIV     clock cycles per UART bit (2..65535)
//   FIFO_DEPTH  byte FIFO entries, power of two (2..256)
//
// Ports
//   clk         single clock, rising edge
//   resetn      asynchronous active-low reset
//   in_byte     byte to transmit, sampled when in_byte_en=1
//   in_byte_en  single-cycle push strobe
//   tx          registered serial line, idle high
//   busy        frame in progress or FIFO non-empty
//   fifo_level  current FIFO occupancy
//   overflow    sticky: a pushed byte was dropped
//   dbg_state   current transmitter state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module soc_uart_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    in_byte,
  input  logic                          in_byte_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;

  logic            w_baud_end;
  logic            w_pop;
  logic            w_push;
  logic [7:0]      w_head;

  // Push handshake: in_byte_en is a one-cycle strobe with no back-pressure.
  // A strobe is accepted when the FIFO has room, or when the transmitter
  // pops on the same edge (the freed slot is reused). Otherwise the byte
  // is dropped and the sticky overflow flag records it.
  assign w_baud_end = (r_baud == CW'(CLK_DIV - 1));
  assign w_pop      = (r_level != '0) &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
  assign w_push     = in_byte_en && ((r_level != LW'(FIFO_DEPTH)) || w_pop);
  assign w_head     = r_mem[r_rd_ptr];

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_byte;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (in_byte_en && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM. tx is registered and updated on the same edge as the
  // state change so each level lasts exactly CLK_DIV cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            // Back-to-back frames: next start bit begins on this edge.
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || (r_level != '0);
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: doc/soc_uart_tx.md
SOC_UART_TX -- requirements
Module: soc_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clock cycles per UART bit; legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning byte FIFO entries; power of two, legal range 2..256.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port in_byte, input, 8 bits, byte to transmit, sampled when in_byte_en=1.
REQ-006 The block SHALL have port in_byte_en, input, 1 bit, single-cycle push strobe from the SoC byte-output register.
REQ-007 The block SHALL have port tx, output, 1 bit, registered UART serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a frame is in progress or the FIFO is non-empty.
REQ-009 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.
REQ-010 The block SHALL have port overflow, output, 1 bit, sticky flag set when a pushed byte is dropped.

Function
REQ-011 The block SHALL push in_byte into the FIFO on a rising edge with in_byte_en=1 if fifo_level<FIFO_DEPTH, or if a pop occurs on the same edge.
REQ-012 The block SHALL drop a push made when full with no same-edge pop, leave FIFO contents unchanged, and set overflow=1 until reset.
REQ-013 The block SHALL use wrap-around read/write pointers modulo FIFO_DEPTH; simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-014 The block SHALL implement states IDLE, START, DATA, STOP plus a baud counter (0..CLK_DIV-1) and a bit index (0..7).
REQ-015 In IDLE with fifo_level>0 the block SHALL pop the FIFO head into a shift register on that edge and enter START with tx=0.
REQ-016 START SHALL hold tx=0 for exactly CLK_DIV cycles, then enter DATA.
REQ-017 DATA SHALL drive 8 bits LSB first, each for exactly CLK_DIV cycles, then enter STOP.
REQ-018 STOP SHALL hold tx=1 for exactly CLK_DIV cycles.
REQ-019 At the end of STOP the block SHALL pop and enter START on the same edge if fifo_level>0, giving gapless frames; otherwise it SHALL enter IDLE.
REQ-020 Each frame SHALL last exactly 10*CLK_DIV cycles.
REQ-021 Latency: with the block idle and empty, a push on edge N SHALL cause a pop on edge N+1 and tx=0 from edge N+1.
REQ-022 busy SHALL equal (state!=IDLE) OR (fifo_level!=0), decoded combinationally from registers.
REQ-023 tx SHALL be driven only from a flop, glitch-free, and SHALL be 1 in IDLE and STOP.

Reset
REQ-024 While resetn=0 the block SHALL force tx=1, busy=0, fifo_level=0, overflow=0, state=IDLE, and counters/pointers=0, regardless of clk.
REQ-025 An assertion of resetn=0 mid-frame SHALL abort the frame immediately, with tx=1 asynchronously, and discard all FIFO contents.
REQ-026 After resetn is released the block SHALL accept a push on the first rising edge.

Verification
REQ-027 Scenario reset: hold resetn=0 for 3 cycles, then release -> tx=1, busy=0, fifo_level=0, overflow=0.
REQ-028 Scenario single byte, CLK_DIV=4: push 0x55 on edge N -> tx from edge N+1 = 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; busy=0 from edge N+41.
REQ-029 Scenario burst, FIFO_DEPTH=4, CLK_DIV=4: push 0x01..0x06 on 6 consecutive edges -> 0x01..0x05 sent as 5 gapless frames (200 cycles); 0x06 dropped; overflow=1.
REQ-030 Scenario full push with pop: FIFO full, push 0xA5 on the STOP-end edge -> byte accepted, fifo_level unchanged, overflow stays 0, 0xA5 sent last.
REQ-031 Scenario mid-frame reset: pull resetn=0 during the DATA bit 3 of 0xF0 -> tx=1 immediately; after release, fifo_level=0, busy=0, and no further frame starts.
REQ-032 Scenario CLK_DIV=2 stress: push 0x00 then 0xFF back-to-back -> 40 cycles total, stop bits both high, no gap between frames.
